// File: rtl/ram_march_bist.sv
// ram_march_bist: four-phase march test engine for a dual-port RAM.
// Phases: write PATTERN (ascending), read/check PATTERN (ascending),
// write ~PATTERN (descending), read/check ~PATTERN (descending).
// Optional macro BIST_STOP_ON_FAIL_EN: the first mismatch aborts the run.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        begin a test (accepted only in IDLE)
//   busy, done                   run in progress / one-cycle end pulse
//   pass, err_count              result summary, valid from done
//   fail_addr, fail_data         address and raw read data of first mismatch
//   ram_we, ram_wr_addr, ram_din write port to RAM
//   ram_re, ram_rd_addr          read port to RAM
//   ram_dout                     registered RAM read data
module ram_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [2:0] {IDLE, WR_BG, RD_BG, WR_INV, RD_INV, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_t state, nxt;
    logic [ADDR_W-1:0] cnt, nxt_cnt;
    logic chk_v;
    logic [ADDR_W-1:0] chk_addr;
    logic [DATA_W-1:0] chk_exp;
    logic mism, nxt_we, nxt_re;
    logic [ADDR_W+1:0] err_nxt;
    always_comb begin
        mism = chk_v && (ram_dout != chk_exp);
        err_nxt = err_count + {{(ADDR_W+1){1'b0}}, mism};
        nxt = state;
        nxt_cnt = cnt;
        case (state)
            IDLE: begin
                nxt = start ? WR_BG : IDLE;
                nxt_cnt = '0;
            end
            WR_BG: begin
                nxt = cnt == LAST ? RD_BG : WR_BG;
                nxt_cnt = cnt + 1'b1;
            end
            RD_BG: begin
                nxt = cnt == LAST ? WR_INV : RD_BG;
                nxt_cnt = cnt == LAST ? LAST : cnt + 1'b1;
            end
            WR_INV: begin
                nxt = cnt == '0 ? RD_INV : WR_INV;
                nxt_cnt = cnt == '0 ? LAST : cnt - 1'b1;
            end
            RD_INV: begin
                nxt = cnt == '0 ? DRAIN : RD_INV;
                nxt_cnt = cnt - 1'b1;
            end
            DRAIN: nxt = DONE;
            default: nxt = IDLE;
        endcase
`ifdef BIST_STOP_ON_FAIL_EN
        if (mism) nxt = DONE;
`else
`endif
        nxt_we = nxt == WR_BG || nxt == WR_INV;
        nxt_re = nxt == RD_BG || nxt == RD_INV;
    end
    // Strobes are registered from the next state so they line up with the state register.
    // A read issued in cycle k is checked at the second edge after it, when ram_dout holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_we <= 1'b0;
            ram_wr_addr <= '0;
            ram_din <= '0;
            ram_re <= 1'b0;
            ram_rd_addr <= '0;
            chk_v <= 1'b0;
            chk_addr <= '0;
            chk_exp <= '0;
        end else begin
            state <= nxt;
            cnt <= nxt_cnt;
            busy <= nxt != IDLE && nxt != DONE;
            done <= nxt == DONE;
            ram_we <= nxt_we;
            ram_wr_addr <= nxt_we ? nxt_cnt : '0;
            ram_din <= nxt == WR_BG ? PATTERN : nxt == WR_INV ? ~PATTERN : '0;
            ram_re <= nxt_re;
            ram_rd_addr <= nxt_re ? nxt_cnt : '0;
            chk_v <= ram_re && nxt != DONE;
            chk_addr <= ram_rd_addr;
            chk_exp <= state == RD_INV ? ~PATTERN : PATTERN;
            if (state == IDLE && start) begin
                pass <= 1'b0;
                err_count <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                if (mism) begin
                    err_count <= err_nxt;
                    if (err_count == '0) begin
                        fail_addr <= chk_addr;
                        fail_data <= ram_dout;
                    end
                end
                if (nxt == DONE) pass <= err_nxt == '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: self-checking bench with a faulty-RAM model and a slot-level reference.
module tb_ram_march_bist;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, pass, ram_we, ram_re;
    logic [5:0] err_count;
    logic [3:0] fail_addr, ram_wr_addr, ram_rd_addr;
    logic [7:0] fail_data, ram_din, ram_dout;
    logic [7:0] mem [16];
    logic [7:0] sa1 [16];
    logic [7:0] sa0 [16];
    localparam logic [7:0] P = 8'hA5;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    int total = 0, bad = 0;
    typedef struct {
        logic [15:0] amask;
        logic [7:0]  bmask;
        bit          one;
        bit          inj;
        int          err;
        int          fa;
        int          fd;
        int          done_n;
    } vec_t;
    vec_t tbl [4];
    ram_march_bist dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        if (ram_re) ram_dout <= (mem[ram_rd_addr] | sa1[ram_rd_addr]) & ~sa0[ram_rd_addr];
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic set_fault(input logic [15:0] am, input logic [7:0] bm, input bit one);
        for (int i = 0; i < 16; i++) begin
            sa1[i] = (am[i] && one) ? bm : 8'h00;
            sa0[i] = (am[i] && !one) ? bm : 8'h00;
        end
    endtask
    // Reference: 32 read slots, ascending reads of P then descending reads of ~P.
    task automatic model(input logic [15:0] am, input logic [7:0] bm, input bit one, output vec_t v);
        int a;
        logic [7:0] e, r;
        v.amask = am; v.bmask = bm; v.one = one; v.inj = 1'b0;
        v.err = 0; v.fa = 0; v.fd = 0; v.done_n = 65;
        for (int s = 0; s < 32; s++) begin
            a = s < 16 ? s : 31 - s;
            e = s < 16 ? P : ~P;
            r = am[a] ? (one ? (e | bm) : (e & ~bm)) : e;
            if (r != e && (!STOP || v.err == 0)) begin
                if (v.err == 0) begin
                    v.fa = a;
                    v.fd = int'(r);
                    if (STOP) v.done_n = 18 + s + (s >= 16 ? 16 : 0);
                end
                v.err++;
            end
        end
    endtask
    task automatic run(input vec_t v);
        int n, nb, ov;
        set_fault(v.amask, v.bmask, v.one);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0; ov = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            if (ram_we && ram_re) ov++;
            @(posedge clk); #1;
            n++;
            start = v.inj && (n == 10 || n == 30);
        end
        start = 1'b0;
        chk("timeout", 32'(n < 200), 32'd1);
        chk("done_edge", 32'(n), 32'(v.done_n));
        chk("busy_cycles", 32'(nb), 32'(v.done_n));
        chk("we_re_overlap", 32'(ov), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("err_count", 32'(err_count), 32'(v.err));
        chk("pass", 32'(pass), 32'(v.err == 0));
        chk("fail_addr", 32'(fail_addr), 32'(v.fa));
        chk("fail_data", 32'(fail_data), 32'(v.fd));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("pass_hold", 32'(pass), 32'(v.err == 0));
    endtask
    initial begin
        vec_t v;
        tbl[0] = '{16'h0000, 8'h00, 1'b0, 1'b0, 0, 0, 0, 65};
        tbl[1] = '{16'h0080, 8'h01, 1'b1, 1'b0, 1, 7, 8'h5B, STOP ? 58 : 65};
        tbl[2] = '{16'h0208, 8'h80, 1'b0, 1'b0, STOP ? 1 : 2, 3, 8'h25, STOP ? 21 : 65};
        tbl[3] = '{16'h0000, 8'h00, 1'b0, 1'b1, 0, 0, 0, 65};
        set_fault(16'h0000, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_fail", 32'({fail_addr, fail_data}), 32'd0);
        chk("rst_strobes", 32'({ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) run(tbl[i]);
        set_fault(16'h0000, 8'h00, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we_re", 32'({ram_we, ram_re}), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        run(tbl[0]);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] am;
            am = (i % 5 == 0) ? 16'h0000 : (16'h1 << $urandom_range(0, 15)) | ((i % 3 == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
            model(am, 8'h1 << $urandom_range(0, 7), 1'($urandom_range(0, 1)), v);
            run(v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
